// File: rtl/layer_sequencer_pkg.sv
// Shared types and defaults for the layer sequencer and its bus multiplexer.
package layer_sequencer_pkg;

    typedef enum logic [2:0] {
        SEQ_IDLE      = 3'd0,
        SEQ_START     = 3'd1,
        SEQ_WAIT_ACK  = 3'd2,
        SEQ_WAIT_DONE = 3'd3,
        SEQ_NEXT      = 3'd4,
        SEQ_FIN       = 3'd5
    } seq_state_t;

    localparam int NUM_W_DEF      = 16;
    localparam int RAM_ADDR_W_DEF = 8;

    // A single-layer chain still carries a 1-bit select.
    function automatic int sel_width(input int layers);
        return (layers > 1) ? $clog2(layers) : 1;
    endfunction

endpackage

// File: rtl/layer_sequencer_bus_mux.sv
// Routes the selected layer's multiplier and weight-RAM requests onto the shared buses;
// everything reads as zero when no layer owns the buses.
module layer_sequencer_bus_mux
    import layer_sequencer_pkg::*;
#(
    parameter int LAYERS     = 3,
    parameter int NUM_W      = NUM_W_DEF,
    parameter int RAM_ADDR_W = RAM_ADDR_W_DEF,
    parameter int SEL_W      = sel_width(LAYERS)
) (
    input  logic                         i_valid,
    input  logic [SEL_W-1:0]             i_sel,
    input  logic [LAYERS-1:0]            i_l_mult_en,
    input  logic [LAYERS-1:0]            i_l_mult_shift,
    input  logic [LAYERS*NUM_W-1:0]      i_l_mult_v1,
    input  logic [LAYERS*NUM_W-1:0]      i_l_mult_v2,
    input  logic [LAYERS-1:0]            i_l_ram_write,
    input  logic [LAYERS*RAM_ADDR_W-1:0] i_l_ram_addr_w,
    input  logic [LAYERS*RAM_ADDR_W-1:0] i_l_ram_addr_r,
    input  logic [LAYERS*NUM_W-1:0]      i_l_ram_data_w,
    output logic                         o_mult_en,
    output logic                         o_mult_shift,
    output logic [NUM_W-1:0]             o_mult_v1,
    output logic [NUM_W-1:0]             o_mult_v2,
    output logic                         o_ram_write,
    output logic [RAM_ADDR_W-1:0]        o_ram_addr_write,
    output logic [RAM_ADDR_W-1:0]        o_ram_addr_read,
    output logic [NUM_W-1:0]             o_ram_data_write
);

    logic w_hit;

    // AND-OR select: at most one layer index matches, so OR-ing the gated lanes is the mux.
    always_comb begin
        w_hit            = 1'b0;
        o_mult_en        = 1'b0;
        o_mult_shift     = 1'b0;
        o_mult_v1        = '0;
        o_mult_v2        = '0;
        o_ram_write      = 1'b0;
        o_ram_addr_write = '0;
        o_ram_addr_read  = '0;
        o_ram_data_write = '0;
        for (int i = 0; i < LAYERS; i++) begin
            w_hit            = i_valid && (i_sel == SEL_W'(i));
            o_mult_en        = o_mult_en    | (w_hit & i_l_mult_en[i]);
            o_mult_shift     = o_mult_shift | (w_hit & i_l_mult_shift[i]);
            o_mult_v1        = o_mult_v1 | ({NUM_W{w_hit}} & i_l_mult_v1[i*NUM_W +: NUM_W]);
            o_mult_v2        = o_mult_v2 | ({NUM_W{w_hit}} & i_l_mult_v2[i*NUM_W +: NUM_W]);
            o_ram_write      = o_ram_write  | (w_hit & i_l_ram_write[i]);
            o_ram_addr_write = o_ram_addr_write
                             | ({RAM_ADDR_W{w_hit}} & i_l_ram_addr_w[i*RAM_ADDR_W +: RAM_ADDR_W]);
            o_ram_addr_read  = o_ram_addr_read
                             | ({RAM_ADDR_W{w_hit}} & i_l_ram_addr_r[i*RAM_ADDR_W +: RAM_ADDR_W]);
            o_ram_data_write = o_ram_data_write
                             | ({NUM_W{w_hit}} & i_l_ram_data_w[i*NUM_W +: NUM_W]);
        end
    end

endmodule

// File: rtl/layer_sequencer.sv
// Walks the layer chain forward (0..LAYERS-1) or backward (LAYERS-1..0), handshaking each
// layer through start / ready and lending it the shared multiplier and weight RAM.
module layer_sequencer
    import layer_sequencer_pkg::*;
#(
    parameter int LAYERS     = 3,
    parameter int NUM_W      = NUM_W_DEF,
    parameter int RAM_ADDR_W = RAM_ADDR_W_DEF,
    localparam int SEL_W     = sel_width(LAYERS)
) (
    input  logic                         i_clk,
    input  logic                         i_nreset,
    input  logic                         i_enable,
    input  logic                         i_run_f,
    input  logic                         i_run_b,
    output logic                         o_busy,
    output logic                         o_done,
    output logic                         o_phase_b,
    output logic [SEL_W-1:0]             o_sel,
    output logic [LAYERS-1:0]            o_l_start_f,
    output logic [LAYERS-1:0]            o_l_start_b,
    output logic [LAYERS-1:0]            o_l_ready_in,
    input  logic [LAYERS-1:0]            i_l_ready_out,
    input  logic [LAYERS-1:0]            i_l_mult_en,
    input  logic [LAYERS-1:0]            i_l_mult_shift,
    input  logic [LAYERS*NUM_W-1:0]      i_l_mult_v1,
    input  logic [LAYERS*NUM_W-1:0]      i_l_mult_v2,
    output logic                         o_mult_en,
    output logic                         o_mult_shift,
    output logic [NUM_W-1:0]             o_mult_v1,
    output logic [NUM_W-1:0]             o_mult_v2,
    input  logic [LAYERS-1:0]            i_l_ram_write,
    input  logic [LAYERS*RAM_ADDR_W-1:0] i_l_ram_addr_w,
    input  logic [LAYERS*RAM_ADDR_W-1:0] i_l_ram_addr_r,
    input  logic [LAYERS*NUM_W-1:0]      i_l_ram_data_w,
    output logic                         o_ram_write,
    output logic [RAM_ADDR_W-1:0]        o_ram_addr_write,
    output logic [RAM_ADDR_W-1:0]        o_ram_addr_read,
    output logic [NUM_W-1:0]             o_ram_data_write
);

    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(LAYERS - 1);

    seq_state_t        r_state;
    logic [SEL_W-1:0]  r_sel;
    logic              r_busy;
    logic              r_done;
    logic              r_phase_b;
    logic [LAYERS-1:0] r_start_f;
    logic [LAYERS-1:0] r_start_b;
    logic [LAYERS-1:0] r_ready_in;

    logic [LAYERS-1:0] w_sel_onehot;
    logic              w_sel_ready;
    logic              w_last;
    logic              w_bus_valid;

    assign w_sel_onehot = LAYERS'(1) << r_sel;
    assign w_sel_ready  = |(i_l_ready_out & w_sel_onehot);
    assign w_last       = r_phase_b ? (r_sel == '0) : (r_sel == LAST_SEL);
    // The ready_in qualifier is held exactly while the selected layer owns the buses.
    assign w_bus_valid  = |r_ready_in;

    // Pass sequencing FSM; every output it drives is a register.
    always_ff @(posedge i_clk or negedge i_nreset) begin
        if (!i_nreset) begin
            r_state    <= SEQ_IDLE;
            r_sel      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_phase_b  <= 1'b0;
            r_start_f  <= '0;
            r_start_b  <= '0;
            r_ready_in <= '0;
        end else if (i_enable) begin
            r_start_f <= '0;
            r_start_b <= '0;
            r_done    <= 1'b0;
            case (r_state)
                SEQ_IDLE: begin
                    if (i_run_f) begin
                        r_sel     <= '0;
                        r_phase_b <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= SEQ_START;
                    end else if (i_run_b) begin
                        r_sel     <= LAST_SEL;
                        r_phase_b <= 1'b1;
                        r_busy    <= 1'b1;
                        r_state   <= SEQ_START;
                    end
                end
                SEQ_START: begin
                    // A layer still reporting busy is never kicked; wait for it.
                    if (w_sel_ready) begin
                        r_start_f  <= r_phase_b ? '0 : w_sel_onehot;
                        r_start_b  <= r_phase_b ? w_sel_onehot : '0;
                        r_ready_in <= w_sel_onehot;
                        r_state    <= SEQ_WAIT_ACK;
                    end
                end
                SEQ_WAIT_ACK: begin
                    if (!w_sel_ready) begin
                        r_state <= SEQ_WAIT_DONE;
                    end
                end
                SEQ_WAIT_DONE: begin
                    if (w_sel_ready) begin
                        r_ready_in <= '0;
                        r_state    <= SEQ_NEXT;
                    end
                end
                SEQ_NEXT: begin
                    if (w_last) begin
                        r_state <= SEQ_FIN;
                    end else begin
                        r_sel   <= r_phase_b ? (r_sel - SEL_W'(1)) : (r_sel + SEL_W'(1));
                        r_state <= SEQ_START;
                    end
                end
                SEQ_FIN: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= SEQ_IDLE;
                end
                default: begin
                    r_ready_in <= '0;
                    r_busy     <= 1'b0;
                    r_state    <= SEQ_IDLE;
                end
            endcase
        end
    end

    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_phase_b    = r_phase_b;
    assign o_sel        = r_sel;
    assign o_l_ready_in = r_ready_in;
    // A pending start pulse is withheld while frozen and delivered on the next enabled cycle.
    assign o_l_start_f  = r_start_f & {LAYERS{i_enable}};
    assign o_l_start_b  = r_start_b & {LAYERS{i_enable}};

    layer_sequencer_bus_mux #(
        .LAYERS     (LAYERS),
        .NUM_W      (NUM_W),
        .RAM_ADDR_W (RAM_ADDR_W),
        .SEL_W      (SEL_W)
    ) u_bus_mux (
        .i_valid          (w_bus_valid),
        .i_sel            (r_sel),
        .i_l_mult_en      (i_l_mult_en),
        .i_l_mult_shift   (i_l_mult_shift),
        .i_l_mult_v1      (i_l_mult_v1),
        .i_l_mult_v2      (i_l_mult_v2),
        .i_l_ram_write    (i_l_ram_write),
        .i_l_ram_addr_w   (i_l_ram_addr_w),
        .i_l_ram_addr_r   (i_l_ram_addr_r),
        .i_l_ram_data_w   (i_l_ram_data_w),
        .o_mult_en        (o_mult_en),
        .o_mult_shift     (o_mult_shift),
        .o_mult_v1        (o_mult_v1),
        .o_mult_v2        (o_mult_v2),
        .o_ram_write      (o_ram_write),
        .o_ram_addr_write (o_ram_addr_write),
        .o_ram_addr_read  (o_ram_addr_read),
        .o_ram_data_write (o_ram_data_write)
    );

endmodule

// File: tb/tb_layer_sequencer.sv
// Bench for layer_sequencer: stub layers with a fixed busy time, random shared-bus traffic,
// and a reference model that tracks which layer should own the buses.
module tb_layer_sequencer;

    localparam int L    = 3;
    localparam int NW   = 16;
    localparam int AW   = 8;
    localparam int BUSW = 3 + 3 * NW + 2 * AW;

    logic            clk     = 1'b0;
    logic            nreset  = 1'b1;
    logic            enable  = 1'b1;
    logic            run_f   = 1'b0;
    logic            run_b   = 1'b0;
    logic            busy, done, phase_b;
    logic [1:0]      sel;
    logic [L-1:0]    start_f, start_b, ready_in, ready_out;
    logic [L-1:0]    l_mult_en, l_mult_shift, l_ram_write;
    logic [L*NW-1:0] l_v1, l_v2, l_dw;
    logic [L*AW-1:0] l_aw, l_ar;
    logic            mult_en, mult_shift, ram_write;
    logic [NW-1:0]   mult_v1, mult_v2, ram_dw;
    logic [AW-1:0]   ram_aw, ram_ar;

    logic [L-1:0]    stub_rdy;
    int              stub_cnt [L];
    int              bcyc [L];
    logic [L-1:0]    stuck = '0;

    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   win = -1;
    bit   low_seen = 1'b0;
    bit   exp_b = 1'b0;
    bit   dir5 = 1'b0;
    int   log_q [$];
    int   dones = 0;
    int   done_cyc = 0;

    assign ready_out = stub_rdy & ~stuck;

    always #5 clk = ~clk;

    layer_sequencer #(.LAYERS(L), .NUM_W(NW), .RAM_ADDR_W(AW)) dut (
        .i_clk(clk), .i_nreset(nreset), .i_enable(enable),
        .i_run_f(run_f), .i_run_b(run_b),
        .o_busy(busy), .o_done(done), .o_phase_b(phase_b), .o_sel(sel),
        .o_l_start_f(start_f), .o_l_start_b(start_b), .o_l_ready_in(ready_in),
        .i_l_ready_out(ready_out),
        .i_l_mult_en(l_mult_en), .i_l_mult_shift(l_mult_shift),
        .i_l_mult_v1(l_v1), .i_l_mult_v2(l_v2),
        .o_mult_en(mult_en), .o_mult_shift(mult_shift),
        .o_mult_v1(mult_v1), .o_mult_v2(mult_v2),
        .i_l_ram_write(l_ram_write), .i_l_ram_addr_w(l_aw), .i_l_ram_addr_r(l_ar),
        .i_l_ram_data_w(l_dw),
        .o_ram_write(ram_write), .o_ram_addr_write(ram_aw), .o_ram_addr_read(ram_ar),
        .o_ram_data_write(ram_dw)
    );

    // Stub layers: drop ready for bcyc cycles after a start pulse, frozen while disabled.
    always @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            stub_rdy <= '1;
            for (int i = 0; i < L; i++) stub_cnt[i] <= 0;
        end else if (enable) begin
            for (int i = 0; i < L; i++) begin
                if (start_f[i] || start_b[i]) begin
                    stub_rdy[i] <= 1'b0;
                    stub_cnt[i] <= bcyc[i] - 1;
                end else if (!stub_rdy[i]) begin
                    if (stub_cnt[i] == 0) stub_rdy[i] <= 1'b1;
                    else stub_cnt[i] <= stub_cnt[i] - 1;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // One clock: new random bus traffic, then compare the DUT with the ownership model.
    task automatic tick();
        logic [BUSW-1:0] exp_bus;
        logic [BUSW-1:0] obs_bus;
        logic [L-1:0]    exp_rin;
        @(negedge clk);
        cyc++;
        l_mult_en    = L'($urandom);
        l_mult_shift = L'($urandom);
        l_ram_write  = L'($urandom);
        for (int i = 0; i < L; i++) begin
            l_v1[i*NW +: NW] = NW'($urandom);
            l_v2[i*NW +: NW] = NW'($urandom);
            l_dw[i*NW +: NW] = NW'($urandom);
            l_aw[i*AW +: AW] = AW'($urandom);
            l_ar[i*AW +: AW] = AW'($urandom);
        end
        if (dir5) begin
            l_v1[NW +: NW] = 16'h0100;
            l_v1[0 +: NW]  = 16'h7FFF;
            l_ar[AW +: AW] = 8'h12;
        end
        #1;
        chk("start_onehot", 128'($countones(start_f | start_b) <= 1), 128'(1));
        for (int k = 0; k < L; k++) begin
            if (start_f[k] || start_b[k]) begin
                chk("start_dir_b", 128'(start_b[k]), 128'(exp_b));
                chk("start_while_stuck", 128'(stuck[k]), 128'(0));
                log_q.push_back(k);
                win = k;
                low_seen = 1'b0;
            end
        end
        if (win >= 0 && !ready_out[win]) low_seen = 1'b1;
        exp_rin = '0;
        exp_bus = '0;
        if (win >= 0) begin
            exp_rin[win] = 1'b1;
            exp_bus = {l_mult_en[win], l_mult_shift[win], l_v1[win*NW +: NW], l_v2[win*NW +: NW],
                       l_ram_write[win], l_aw[win*AW +: AW], l_ar[win*AW +: AW], l_dw[win*NW +: NW]};
            chk("sel", 128'(sel), 128'(win));
            if (dir5 && win == 1) begin
                chk("l1_mult_v1", 128'(mult_v1), 128'(16'h0100));
                chk("l1_ram_addr_r", 128'(ram_ar), 128'(8'h12));
            end
        end
        obs_bus = {mult_en, mult_shift, mult_v1, mult_v2, ram_write, ram_aw, ram_ar, ram_dw};
        chk("ready_in", 128'(ready_in), 128'(exp_rin));
        chk("shared_bus", 128'(obs_bus), 128'(exp_bus));
        if (done) begin
            dones++;
            done_cyc = cyc;
        end
        // Ownership ends after the cycle in which the layer reports ready again.
        if (win >= 0 && low_seen && ready_out[win]) win = -1;
    endtask

    task automatic run_pass(input bit rf, input bit rb, input int inj_b_at, input int rel_at,
                            input int dis_at, input int dis_len, input bit chk_lat);
        int set_cyc;
        int lat;
        exp_b = rb && !rf;
        log_q.delete();
        dones = 0;
        lat = 1 + dis_len;
        for (int k = 0; k < L; k++) lat += bcyc[k] + 4;
        run_f = rf;
        run_b = rb;
        set_cyc = cyc;
        for (int t = 1; t <= 800 && dones == 0; t++) begin
            tick();
            if (t == 2) chk("busy_mid", 128'(busy), 128'(1));
            run_f = 1'b0;
            run_b = 1'b0;
            if (t == inj_b_at) run_b = 1'b1;
            if (t == rel_at) stuck = '0;
            if (t == dis_at) enable = 1'b0;
            if (t == dis_at + dis_len) enable = 1'b1;
        end
        chk("done_seen", 128'(dones), 128'(1));
        if (chk_lat) chk("latency", 128'(done_cyc - set_cyc - 1), 128'(lat));
        chk("order_len", 128'(log_q.size()), 128'(L));
        for (int i = 0; i < log_q.size() && i < L; i++)
            chk("order", 128'(log_q[i]), 128'(exp_b ? (L - 1 - i) : i));
        chk("busy_after", 128'(busy), 128'(0));
        chk("phase_b", 128'(phase_b), 128'(exp_b));
        chk("sel_after", 128'(sel), 128'(exp_b ? 0 : L - 1));
        for (int t = 0; t < 12; t++) tick();
        chk("no_extra_start", 128'(log_q.size()), 128'(L));
        chk("no_extra_done", 128'(dones), 128'(1));
        chk("busy_idle", 128'(busy), 128'(0));
    endtask

    initial begin
        for (int k = 0; k < L; k++) bcyc[k] = 5;
        #2 nreset = 1'b0;
        tick();
        tick();
        chk("rst_status", 128'({busy, done, phase_b, sel}), 128'(0));
        chk("rst_pulses", 128'({start_f, start_b, ready_in}), 128'(0));
        nreset = 1'b1;
        tick();

        run_pass(1'b1, 1'b0, -1, -1, -1, 0, 1'b1);
        run_pass(1'b0, 1'b1, -1, -1, -1, 0, 1'b1);
        run_pass(1'b1, 1'b1, 15, -1, -1, 0, 1'b1);

        stuck = 3'b010;
        run_pass(1'b1, 1'b0, -1, 40, -1, 0, 1'b0);

        dir5 = 1'b1;
        run_pass(1'b1, 1'b0, -1, -1, -1, 0, 1'b1);
        dir5 = 1'b0;

        run_pass(1'b1, 1'b0, -1, -1, 15, 10, 1'b1);

        // Reset in the middle of layer 1's busy window, then restart from layer 0.
        exp_b = 1'b0;
        log_q.delete();
        run_f = 1'b1;
        tick();
        run_f = 1'b0;
        for (int t = 2; t <= 15; t++) tick();
        chk("pre_rst_sel", 128'(sel), 128'(1));
        chk("pre_rst_busy", 128'(busy), 128'(1));
        nreset = 1'b0;
        #1;
        chk("mid_rst_status", 128'({busy, done, phase_b, sel}), 128'(0));
        chk("mid_rst_pulses", 128'({start_f, start_b, ready_in}), 128'(0));
        chk("mid_rst_bus", 128'({mult_en, mult_shift, mult_v1, mult_v2, ram_write, ram_aw, ram_ar, ram_dw}),
            128'(0));
        win = -1;
        tick();
        tick();
        nreset = 1'b1;
        run_pass(1'b1, 1'b0, -1, -1, -1, 0, 1'b1);

        for (int p = 0; p < 4; p++) begin
            for (int k = 0; k < L; k++) bcyc[k] = int'($urandom_range(1, 8));
            if ($urandom_range(0, 1) == 1) run_pass(1'b0, 1'b1, -1, -1, -1, 0, 1'b1);
            else run_pass(1'b1, 1'b0, -1, -1, -1, 0, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
